// File: rtl/layer13_global_avgpool.sv
// Global average pool: accumulates PIX pixels per channel, then streams
// CH rounded, saturated channel averages to the downstream FC layer.
module layer13_global_avgpool #(
    parameter int CH    = 1024,
    parameter int PIX   = 49,
    parameter int DW    = 8,
    parameter int AW    = 14,
    parameter int RECIP = 1337,
    parameter int SHIFT = 16
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic [DW-1:0] poolIn_V_V_TDATA,
    input  logic          poolIn_V_V_TVALID,
    output logic          poolIn_V_V_TREADY,
    output logic [DW-1:0] poolRes_V_V_TDATA,
    output logic          poolRes_V_V_TVALID,
    input  logic          poolRes_V_V_TREADY,
    output logic          frame_done
);

    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int PCW = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int PW  = AW + SHIFT;

    localparam logic [CW-1:0]  CH_LAST  = CW'(CH - 1);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(PIX - 1);
    localparam logic [AW:0]    AVG_MAX  = (AW + 1)'(2 ** DW - 1);

    typedef enum logic {ACC, DRAIN} poolState_e;

    poolState_e stateReg, stateNext;

    logic [CW-1:0]  chCnt;
    logic [PCW-1:0] pixCnt;
    logic [CW-1:0]  outCnt;
    logic [CW-1:0]  rdCnt;
    logic           rdDone;
    logic           inReadyReg;

    logic           s1Valid;
    logic           s1First;
    logic [CW-1:0]  s1Ch;
    logic [DW-1:0]  s1X;

    logic [AW-1:0]  accMem [CH];
    logic [AW-1:0]  rdData;
    logic           drainRdValid;

    logic           outValidReg;
    logic [DW-1:0]  outDataReg;
    logic           frameDoneReg;

    logic           inAccept;
    logic           lastIn;
    logic           outFire;
    logic           lastOut;
    logic           loadOut;
    logic           issueRead;
    logic           rdEn;
    logic [CW-1:0]  rdAddr;

    logic [PW-1:0]  prod;
    logic [PW:0]    rounded;
    logic [AW:0]    quotient;
    logic [DW-1:0]  avgSat;

    assign inAccept  = poolIn_V_V_TVALID & inReadyReg;
    assign lastIn    = inAccept & (chCnt == CH_LAST) & (pixCnt == PIX_LAST);
    assign outFire   = outValidReg & poolRes_V_V_TREADY;
    assign lastOut   = outFire & (outCnt == CH_LAST);

    // A read result moves to the output register only when that register is
    // empty or being emptied; a new read is issued only when its result has
    // somewhere to go, so backpressure freezes rdData in place.
    assign loadOut   = drainRdValid & (~outValidReg | poolRes_V_V_TREADY);
    assign issueRead = (stateReg == DRAIN) & ~rdDone & (~drainRdValid | loadOut);

    assign rdEn   = inAccept | issueRead;
    assign rdAddr = (stateReg == DRAIN) ? rdCnt : chCnt;

    assign prod     = PW'(rdData) * PW'(RECIP);
    assign rounded  = (PW + 1)'(prod) + (PW + 1)'(2 ** (SHIFT - 1));
    assign quotient = (AW + 1)'(rounded >> SHIFT);
    assign avgSat   = (quotient > AVG_MAX) ? {DW{1'b1}} : quotient[DW-1:0];

    assign poolIn_V_V_TREADY  = inReadyReg;
    assign poolRes_V_V_TDATA  = outDataReg;
    assign poolRes_V_V_TVALID = outValidReg;
    assign frame_done         = frameDoneReg;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ACC:     if (lastIn)  stateNext = DRAIN;
            DRAIN:   if (lastOut) stateNext = ACC;
            default: stateNext = ACC;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stateReg <= ACC;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Accumulator RAM. Consecutive beats address different channels, so the
    // write of beat n never collides with the read of beat n+1.
    always_ff @(posedge ap_clk) begin
        if (s1Valid) begin
            accMem[s1Ch] <= s1First ? AW'(s1X) : rdData + AW'(s1X);
        end
        if (rdEn) begin
            rdData <= accMem[rdAddr];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            chCnt        <= '0;
            pixCnt       <= '0;
            outCnt       <= '0;
            rdCnt        <= '0;
            rdDone       <= 1'b0;
            inReadyReg   <= 1'b0;
            s1Valid      <= 1'b0;
            s1First      <= 1'b0;
            s1Ch         <= '0;
            s1X          <= '0;
            drainRdValid <= 1'b0;
            outValidReg  <= 1'b0;
            outDataReg   <= '0;
            frameDoneReg <= 1'b0;
        end else begin
            inReadyReg   <= (stateNext == ACC);
            frameDoneReg <= lastOut;

            s1Valid <= inAccept;
            if (inAccept) begin
                s1Ch    <= chCnt;
                s1X     <= poolIn_V_V_TDATA;
                s1First <= (pixCnt == '0);
                if (chCnt == CH_LAST) begin
                    chCnt  <= '0;
                    pixCnt <= (pixCnt == PIX_LAST) ? '0 : pixCnt + 1'b1;
                end else begin
                    chCnt <= chCnt + 1'b1;
                end
            end

            if (issueRead) begin
                drainRdValid <= 1'b1;
                if (rdCnt == CH_LAST) begin
                    rdCnt  <= '0;
                    rdDone <= 1'b1;
                end else begin
                    rdCnt <= rdCnt + 1'b1;
                end
            end else if (loadOut) begin
                drainRdValid <= 1'b0;
            end

            if (loadOut) begin
                outValidReg <= 1'b1;
                outDataReg  <= avgSat;
            end else if (outFire) begin
                outValidReg <= 1'b0;
            end

            if (outFire) begin
                outCnt <= (outCnt == CH_LAST) ? '0 : outCnt + 1'b1;
            end

            if (lastOut) begin
                rdDone <= 1'b0;
                rdCnt  <= '0;
            end
        end
    end

endmodule

// File: doc/layer13_global_avgpool.md
Name: layer13_global_avgpool

Overview:
Global average pool that sits directly upstream of the fully-connected layer and feeds its 8-bit activation stream. It consumes the 7x7x1024 quantised feature map, one 8-bit activation per beat, in pixel-major, channel-minor order. It accumulates per-channel sums in an internal accumulator array, then streams 1024 rounded 8-bit channel averages in channel order. Output timing and data match the FC layer's activation input, so the output connects to it without glue.

Parameters:
CH, 1024, channels per frame; also the number of output beats.
PIX, 49, spatial pixels per frame (7x7).
DW, 8, activation width, in and out.
AW, 14, accumulator width; must hold PIX*(2^DW-1), which is 12495 for the defaults.
RECIP, 1337, round(2^SHIFT/PIX).
SHIFT, 16, reciprocal scaling shift.

Ports:
ap_clk  in  1  clock; all logic is rising-edge.
ap_rst_n  in  1  asynchronous active-low reset.
poolIn_V_V_TDATA  in  DW  input activation.
poolIn_V_V_TVALID  in  1  input valid.
poolIn_V_V_TREADY  out  1  input ready.
poolRes_V_V_TDATA  out  DW  averaged activation to the FC layer.
poolRes_V_V_TVALID  out  1  output valid.
poolRes_V_V_TREADY  in  1  output ready.
frame_done  out  1  one-cycle pulse when the last output beat of a frame is accepted.

Behaviour:
- Reset (async assert, sync release):
  - state=ACC; ch_cnt=0, pix_cnt=0, out_cnt=0.
  - poolIn_V_V_TREADY=0 while reset is asserted, 1 from the first cycle after release.
  - poolRes_V_V_TVALID=0, poolRes_V_V_TDATA=0, frame_done=0.
  - Accumulator contents are don't-care, because pixel 0 overwrites them.
- An input beat is accepted only on TVALID&TREADY. An output beat is transferred only on TVALID&TREADY.
- ACC state:
  - TREADY=1 continuously; throughput 1 beat/cycle with no bubbles.
  - On each accept: if pix_cnt==0 then acc[ch_cnt]=x, else acc[ch_cnt]=acc[ch_cnt]+x (unsigned, AW bits, cannot overflow).
  - ch_cnt increments and wraps CH-1->0. On that wrap pix_cnt increments.
  - Accept with pix_cnt==PIX-1 and ch_cnt==CH-1: go to DRAIN; TREADY=0 from the next cycle.
  - A read-modify-write pipeline is allowed. Because CH>=3, consecutive beats never hit the same channel, but a pending write must be visible before the next read of that address.
- DRAIN state:
  - TREADY=0.
  - For out_cnt=0..CH-1: avg = (acc[out_cnt]*RECIP + 2^(SHIFT-1)) >> SHIFT, saturated to 2^DW-1. The product uses AW+SHIFT bits.
  - First TVALID rises at most 3 cycles after the final input accept. Sustained rate is 1 beat/cycle while TREADY=1.
  - TDATA/TVALID are registered and held stable while TVALID=1 and TREADY=0; there is no combinational path from TREADY to TVALID.
  - Backpressure stalls the read pipeline without loss or duplication.
  - Handshake on beat CH-1: TVALID=0 next cycle, frame_done=1 for exactly one cycle, counters cleared, state=ACC, TREADY=1 on that same next cycle.
- Input TVALID during DRAIN is ignored, because TREADY=0; upstream must hold the beat.
- Reset mid-frame (either state): everything returns to its reset values. The partial frame is discarded and the next accepted beat is treated as pixel 0 / channel 0.
- Frames are back-to-back with no gap required beyond the DRAIN period.

Test Plan:
- Constant frame, all 49x1024 inputs = 10 -> 1024 outputs all equal to 10 (490*1337+32768 >>16 = 10); frame_done pulses once.
- Input value = pixel index p (0..48) for every channel -> every output = 24 (sum 1176).
- All inputs 255 -> all outputs 255 (12495 path, no wrap, saturation boundary). Input channel c = c mod 256 at every pixel -> output c equals c mod 256.
- Random output TREADY (~50% duty) on a random frame -> output sequence matches the golden model exactly. TDATA is stable while stalled, and no beat is dropped or duplicated.
- Random input TVALID gaps plus two back-to-back frames -> second frame's results are independent of the first. TREADY stays 0 throughout DRAIN and returns to 1 the cycle after frame_done.
- Assert ap_rst_n low mid-ACC (after 1000 beats) and again mid-DRAIN (after 300 outputs) -> outputs are immediately 0 and valid deasserts. The next full frame produces correct averages.
